mul_seq_ctrl: RTL

Sequencing controller for the radix-4 Booth multiplier (32x32 signed, two register stages, fixed 2-cycle latency, no stall input) in the RV32IM M-extension path. It accepts one multiply request at a time over a valid/ready handshake and drives operands into the multiplier. It applies the unsigned-operand correction needed for MULH/MULHSU/MULHU, then returns a 32-bit result with its destination tag. A one-entry operand/product cache makes the recommended MULH-then-MUL sequence on the same operands complete in one cycle.

---
 rtl/mul_seq_ctrl.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl
// Sequencing controller for a 2-cycle radix-4 Booth multiplier (signed a*b)
// in the RV32IM M-extension path. It takes one request at a time and holds
// its operands on mul_x/mul_y. It applies the upper-word correction for
// MULHSU/MULHU, then returns the 32-bit result with its destination tag.
// A one-entry operand/product cache lets a MULH followed by a MUL on the
// same operands finish in a single cycle.
//
// Ports:
//   CLK, RST_N           clock (rising edge), async active-low reset
//   req_valid/req_ready  request handshake (ready only while idle)
//   req_op               00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//   req_a, req_b         rs1 / rs2 values
//   req_tag              destination tag, returned unchanged
//   kill                 pipeline flush, aborts any in-flight operation
//   mul_x, mul_y         operands to the multiplier
//   mul_p                signed 64-bit product from the multiplier
//   rsp_valid/rsp_ready  response handshake
//   rsp_data, rsp_tag    result and its tag
`timescale 1ns/1ps
module mul_seq_ctrl #(
   parameter int XLEN = 32,
   parameter int TAGW = 5
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [1:0]        req_op,
   input  logic [XLEN-1:0]   req_a,
   input  logic [XLEN-1:0]   req_b,
   input  logic [TAGW-1:0]   req_tag,
   input  logic              kill,
   output logic [XLEN-1:0]   mul_x,
   output logic [XLEN-1:0]   mul_y,
   input  logic [2*XLEN-1:0] mul_p,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [XLEN-1:0]   rsp_data,
   output logic [TAGW-1:0]   rsp_tag
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_M1   = 3'd1;
   localparam logic [2:0] S_M2   = 3'd2;
   localparam logic [2:0] S_FIX  = 3'd3;
   localparam logic [2:0] S_RESP = 3'd4;

   localparam logic [1:0] OP_MUL    = 2'b00;
   localparam logic [1:0] OP_MULH   = 2'b01;
   localparam logic [1:0] OP_MULHSU = 2'b10;
   localparam logic [1:0] OP_MULHU  = 2'b11;

   // The multiplier always forms the signed product. An operand treated as
   // unsigned with its top bit set is really worth 2^XLEN more, so the other
   // operand must be added into the upper word (mod 2^XLEN).
   function automatic logic [XLEN-1:0] fix_result(
      input logic [1:0]        op,
      input logic [2*XLEN-1:0] p,
      input logic [XLEN-1:0]   a,
      input logic [XLEN-1:0]   b
   );
      logic [XLEN-1:0] hi;
      logic [XLEN-1:0] adj_a;
      logic [XLEN-1:0] adj_b;
      hi    = p[2*XLEN-1:XLEN];
      adj_a = b[XLEN-1] ? a : {XLEN{1'b0}};
      adj_b = a[XLEN-1] ? b : {XLEN{1'b0}};
      case (op)
         OP_MUL:    fix_result = p[XLEN-1:0];
         OP_MULH:   fix_result = hi;
         OP_MULHSU: fix_result = hi + adj_a;
         OP_MULHU:  fix_result = hi + adj_a + adj_b;
         default:   fix_result = hi;
      endcase
   endfunction

   logic [2:0]        state_q, state_d;
   logic              req_ready_q, req_ready_d;
   logic [1:0]        op_q, op_d;
   logic [XLEN-1:0]   a_q, a_d;
   logic [XLEN-1:0]   b_q, b_d;
   logic [TAGW-1:0]   tag_q, tag_d;
   logic              hit_q, hit_d;
   logic              cache_vld_q, cache_vld_d;
   logic [XLEN-1:0]   cache_a_q, cache_a_d;
   logic [XLEN-1:0]   cache_b_q, cache_b_d;
   logic [2*XLEN-1:0] cache_p_q, cache_p_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [XLEN-1:0]   rsp_data_q, rsp_data_d;
   logic [TAGW-1:0]   rsp_tag_q, rsp_tag_d;
   logic [2*XLEN-1:0] raw_p_s;

   // Next-state logic for the sequencer, operand latch, cache and response.
   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      a_d         = a_q;
      b_d         = b_q;
      tag_d       = tag_q;
      hit_d       = hit_q;
      cache_vld_d = cache_vld_q;
      cache_a_d   = cache_a_q;
      cache_b_d   = cache_b_q;
      cache_p_d   = cache_p_q;
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;
      rsp_tag_d   = rsp_tag_q;
      raw_p_s     = hit_q ? cache_p_q : mul_p;

      if (kill) begin
         // Flush wins over everything; the cache keeps its contents because
         // they depend only on the operands.
         state_d     = S_IDLE;
         rsp_valid_d = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (req_valid) begin
                  op_d  = req_op;
                  a_d   = req_a;
                  b_d   = req_b;
                  tag_d = req_tag;
                  hit_d = cache_vld_q && (req_a == cache_a_q) && (req_b == cache_b_q);
                  state_d = hit_d ? S_FIX : S_M1;
               end else begin
                  state_d = S_IDLE;
               end
            end
            S_M1: state_d = S_M2;
            S_M2: state_d = S_FIX;
            S_FIX: begin
               rsp_data_d  = fix_result(op_q, raw_p_s, a_q, b_q);
               rsp_tag_d   = tag_q;
               rsp_valid_d = 1'b1;
               state_d     = S_RESP;
               if (!hit_q) begin
                  cache_vld_d = 1'b1;
                  cache_a_d   = a_q;
                  cache_b_d   = b_q;
                  cache_p_d   = raw_p_s;
               end else begin
                  cache_vld_d = cache_vld_q;
               end
            end
            S_RESP: begin
               if (rsp_ready) begin
                  rsp_valid_d = 1'b0;
                  state_d     = S_IDLE;
               end else begin
                  state_d = S_RESP;
               end
            end
            default: begin
               state_d     = S_IDLE;
               rsp_valid_d = 1'b0;
            end
         endcase
      end
      req_ready_d = (state_d == S_IDLE);
   end

   // Sequencer, operand, cache and response registers.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q     <= S_IDLE;
         req_ready_q <= 1'b1;
         op_q        <= 2'b00;
         a_q         <= {XLEN{1'b0}};
         b_q         <= {XLEN{1'b0}};
         tag_q       <= {TAGW{1'b0}};
         hit_q       <= 1'b0;
         cache_vld_q <= 1'b0;
         cache_a_q   <= {XLEN{1'b0}};
         cache_b_q   <= {XLEN{1'b0}};
         cache_p_q   <= {(2*XLEN){1'b0}};
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= {XLEN{1'b0}};
         rsp_tag_q   <= {TAGW{1'b0}};
      end else begin
         state_q     <= state_d;
         req_ready_q <= req_ready_d;
         op_q        <= op_d;
         a_q         <= a_d;
         b_q         <= b_d;
         tag_q       <= tag_d;
         hit_q       <= hit_d;
         cache_vld_q <= cache_vld_d;
         cache_a_q   <= cache_a_d;
         cache_b_q   <= cache_b_d;
         cache_p_q   <= cache_p_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_tag_q   <= rsp_tag_d;
      end
   end

   assign req_ready = req_ready_q;
   assign mul_x     = a_q;
   assign mul_y     = b_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_tag   = rsp_tag_q;

endmodule
